mem_fill_responder: RTL and testbench
=====================================

Name: mem_fill_responder

Overview:
Pipelined, fixed-latency, single-port data memory model that answers the cache fill FSM's read requests.
- Accepts one read or write request per cycle.
- Returns read data with a one-cycle data_valid pulse exactly LATENCY cycles after the request was accepted.
- Sits behind the cache miss path; serves 8-word (16-byte) line fills as back-to-back or spaced requests.

Parameters:
ADDR_W, 16, byte-address width; bit 0 ignored for the word index.
DEPTH_LOG2, 10, log2 of word count; index = addr[DEPTH_LOG2:1].
LATENCY, 4, cycles from accepted read to data_valid; legal range 1..8.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
enable  in  1  request strobe; one request per asserted cycle.
wr  in  1  1 = write, 0 = read; sampled only when enable=1.
addr  in  16  byte address of the request.
data_in  in  16  write data.
data_out  out  16  read data; valid only when data_valid=1.
data_valid  out  1  one-cycle pulse per returned read.
busy  out  1  high while any read is in flight.
outstanding  out  4  count of reads in flight (0..LATENCY).

Behaviour:
- Reset (async, rst=1): pipeline valid bits cleared, data_valid=0, data_out=0, busy=0, outstanding=0. Array contents are not reset and are undefined until written.
- Write (enable=1, wr=1): mem[idx] <= data_in at that rising edge. No response and no data_valid.
- Read (enable=1, wr=0):
  - mem[idx] is sampled at the accepting edge.
  - Value and valid bit enter stage 1 of a LATENCY-deep shift pipeline.
  - Read accepted at edge N gives data_valid=1 and data_out=value during the cycle after edge N+LATENCY-1, i.e. registered outputs change at edge N+LATENCY-1.
  - LATENCY=4 therefore gives 4 cycles of enable-to-valid visible at the negedge sampling the bench uses.
- Pipelining: a new read is accepted every cycle. Responses come back strictly in order. No backpressure; the requester must always accept a response.
- Idle cycle (enable=0): a bubble enters the pipeline.
- Hazards:
  - A read always returns the array value at its own accept edge.
  - A write in a later cycle does not alter a read already in flight.
  - Write and read to the same index cannot occur in the same cycle (single port).
- Addressing: bit 0 is ignored. Address bits above DEPTH_LOG2 are ignored, so the address space wraps modulo 2^(DEPTH_LOG2+1) bytes.
- data_out holds its last value when data_valid=0. It is not forced to zero.
- Counters:
  - outstanding = number of set valid bits in the pipeline.
  - Per cycle it increments on an accepted read and decrements on a retiring response. Simultaneous accept and retire leave it unchanged.
  - busy = (outstanding != 0).
- Reset mid-burst: all in-flight reads are dropped immediately. No data_valid after reset deasserts until new reads are accepted.

Optional Feature:
Macro MEM_RESP_ERR_EN adds output resp_err (1 bit), aligned with data_valid.
- With the macro: resp_err=1 on a response whose request address had bit 0 set, or had any bit above DEPTH_LOG2 set. The read still returns mem[idx]. A write under either condition is dropped; the array is left unchanged and the write is not counted. resp_err resets to 0.
- Without the macro: the port is absent, every address is wrapped/aligned silently, and no error state exists.

Decomposition:
- Shared package holds:
  - localparam defaults: MEM_LATENCY_DEF=4, MEM_DEPTH_LOG2_DEF=10.
  - Typedef for the pipeline stage struct {valid, data, err}.
- One natural sub-module, resp_pipe_stage: a single register stage with async active-high reset clearing valid/err.
- mem_fill_responder instantiates LATENCY copies of resp_pipe_stage plus the array and the outstanding counter.

Test Plan:
- Reset, write 0xBEEF to 0x0040, idle, read 0x0040 at edge N -> data_valid pulses one cycle after edge N+3 with data_out=0xBEEF; outstanding goes 1,1,1,1,0.
- Write words 0x1230..0x123E with data = addr, then 8 back-to-back reads -> 8 consecutive data_valid pulses in order 0x1230..0x123E; outstanding peaks at 4; busy falls the cycle after the last pulse.
- Read 0x0010 (holds 0x1111), next cycle write 0x2222 to 0x0010, read again -> first response 0x1111, second 0x2222.
- Reads spaced by idle cycles (request every 5 cycles, fill-FSM style) -> each response exactly LATENCY after its request; data_valid never wider than one cycle.
- Assert rst with 3 reads in flight -> data_valid, busy, outstanding go 0 immediately; no response appears after release.
- MEM_RESP_ERR_EN: read 0x0041 -> resp_err=1 with data_valid, data = mem[0x20]; write to 0x0801 (DEPTH_LOG2=10) -> array unchanged, verified by a readback.

Source files
------------

// File: rtl/mem_fill_responder_pkg.sv
// Shared defaults and the response pipeline stage type for mem_fill_responder.
package mem_fill_responder_pkg;

    localparam int MEM_LATENCY_DEF    = 4;
    localparam int MEM_DEPTH_LOG2_DEF = 10;
    localparam int MEM_DATA_W         = 16;

    typedef struct packed {
        logic                  valid;
        logic [MEM_DATA_W-1:0] data;
        logic                  err;
    } resp_stage_t;

endpackage

// File: rtl/mem_fill_responder_resp_pipe_stage.sv
// One register stage of the read-response pipeline; payload is held across bubbles
// so the final stage keeps presenting the last returned word.
module resp_pipe_stage
    import mem_fill_responder_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  resp_stage_t d_i,
    output resp_stage_t q_o
);

    resp_stage_t stage_q;
    resp_stage_t stage_d;

    always_comb begin
        stage_d       = stage_q;
        stage_d.valid = d_i.valid;
        if (d_i.valid) begin
            stage_d.data = d_i.data;
            stage_d.err  = d_i.err;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/mem_fill_responder.sv
// Fixed-latency single-port data memory answering cache line-fill reads.
// Optional MEM_RESP_ERR_EN adds resp_err for misaligned / out-of-range addresses.
module mem_fill_responder
    import mem_fill_responder_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2_DEF,
    parameter int LATENCY    = MEM_LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [MEM_DATA_W-1:0] data_in,
    output logic [MEM_DATA_W-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy,
`ifdef MEM_RESP_ERR_EN
    output logic                  resp_err,
`endif
    output logic [3:0]            outstanding
);

    logic [MEM_DATA_W-1:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  addr_err;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  retire;
    resp_stage_t           stage_in;
    resp_stage_t           pipe [LATENCY];
    resp_stage_t           resp;
    logic [3:0]            outstanding_q;
    logic [3:0]            outstanding_d;

    assign idx = addr[DEPTH_LOG2:1];

`ifdef MEM_RESP_ERR_EN
    assign addr_err = addr[0] | (|addr[ADDR_W-1:DEPTH_LOG2+1]);
    assign resp_err = resp.valid & resp.err;
`else
    logic unused_bits;
    assign addr_err    = 1'b0;
    assign unused_bits = ^{addr[0], addr[ADDR_W-1:DEPTH_LOG2+1], resp.err};
`endif

    assign rd_accept = enable & ~wr;
    assign wr_accept = enable & wr & ~addr_err;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[idx] <= data_in;
        end
    end

    // The array word is captured by stage 0 at the accept edge, so later writes
    // cannot disturb a read already in flight.
    always_comb begin
        stage_in       = '0;
        stage_in.valid = rd_accept;
        stage_in.data  = mem[idx];
        stage_in.err   = addr_err;
    end

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        if (g == 0) begin : g_first
            resp_pipe_stage u_stage (
                .clk_i (clk),
                .rst_i (rst),
                .d_i   (stage_in),
                .q_o   (pipe[g])
            );
        end else begin : g_next
            resp_pipe_stage u_stage (
                .clk_i (clk),
                .rst_i (rst),
                .d_i   (pipe[g-1]),
                .q_o   (pipe[g])
            );
        end
    end

    assign resp   = pipe[LATENCY-1];
    assign retire = resp.valid;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({rd_accept, retire})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign data_out    = resp.data;
    assign data_valid  = resp.valid;
    assign outstanding = outstanding_q;
    assign busy        = (outstanding_q != 4'd0);

endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed scoreboard bench for mem_fill_responder (MEM_RESP_ERR_EN optional).
module tb_mem_fill_responder;

    localparam int LAT = 4;
    localparam int DL2 = 10;
    localparam int AW  = 16;
`ifdef MEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;
    logic [3:0]  outstanding;
`ifdef MEM_RESP_ERR_EN
    logic        resp_err;
`endif

    always #5 clk = ~clk;

    mem_fill_responder #(
        .ADDR_W     (AW),
        .DEPTH_LOG2 (DL2),
        .LATENCY    (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .wr          (wr),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
`ifdef MEM_RESP_ERR_EN
        .resp_err    (resp_err),
`endif
        .outstanding (outstanding)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [int];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          mon_n;
    int          peak;
    bit          mon_on = 1'b0;
    logic [15:0] last_exp;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int idx_of(input logic [15:0] a);
        return int'((a >> 1) & 16'((1 << DL2) - 1));
    endfunction

    function automatic logic bad_addr(input logic [15:0] a);
        logic raw;
        raw = a[0] | ((a >> (DL2 + 1)) != 16'd0);
        return ERR_EN && raw;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = a;
        data_in = d;
        if (!bad_addr(a)) model[idx_of(a)] = d;
        @(negedge clk);
        enable = 1'b0;
        wr     = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a);
        exp_t x;
        enable  = 1'b1;
        wr      = 1'b0;
        addr    = a;
        data_in = 16'($urandom);
        x.due   = cyc + LAT;
        x.data  = model[idx_of(a)];
        x.err   = bad_addr(a);
        sb.push_back(x);
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        wr     = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Response monitor: in-flight count, exact arrival cycle, data, and hold behaviour.
    always @(negedge clk) begin
        if (mon_on) begin
            mon_n = 0;
            foreach (sb[i]) if (sb[i].due - LAT + 1 <= cyc) mon_n++;
            chk("outstanding", 32'(outstanding), 32'(mon_n));
            chk("busy", 32'(busy), 32'(mon_n != 0));
            if (data_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'(data_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rd_cycle", 32'(cyc), 32'(mon_e.due));
                    chk("rd_data", 32'(data_out), 32'(mon_e.data));
`ifdef MEM_RESP_ERR_EN
                    chk("rd_err", 32'(resp_err), 32'(mon_e.err));
`endif
                    last_exp = mon_e.data;
                end
            end else begin
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    chk("missing_valid", 32'(data_valid), 32'd1);
                    void'(sb.pop_front());
                end
                chk("hold_data_out", 32'(data_out), 32'(last_exp));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        wr       = 1'b0;
        addr     = '0;
        data_in  = '0;
        last_exp = '0;
        repeat (2) @(negedge clk);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        rst    = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);

        // single write / read
        do_write(16'h0040, 16'hBEEF);
        idle(1);
        do_read(16'h0040);
        idle(LAT + 2);

        // line fill, back-to-back
        for (int i = 0; i < 8; i++) do_write(16'(16'h1230 + 2 * i), 16'(16'h1230 + 2 * i));
        peak = 0;
        for (int i = 0; i < 8; i++) begin
            do_read(16'(16'h1230 + 2 * i));
            if (int'(outstanding) > peak) peak = int'(outstanding);
        end
        idle(LAT + 2);
        chk("peak_outstanding", 32'(peak), 32'(LAT));

        // read, then overwrite, then read again
        do_write(16'h0010, 16'h1111);
        do_read(16'h0010);
        do_write(16'h0010, 16'h2222);
        do_read(16'h0010);
        idle(LAT + 2);

        // spaced fill requests
        for (int i = 0; i < 4; i++) begin
            do_read(16'(16'h1230 + 4 * i));
            idle(4);
        end
        idle(LAT);

        // misaligned and out-of-range addresses
        do_read(16'h0041);
        do_write(16'h0000, 16'hAAAA);
        do_write(16'h0801, 16'h5555);
        do_read(16'h0000);
        do_read(16'h0841);
        idle(LAT + 2);

        // reset with three reads in flight
        do_read(16'h1230);
        do_read(16'h1232);
        do_read(16'h1234);
        #2;
        rst = 1'b1;
        sb.delete();
        last_exp = '0;
        #1;
        chk("midrst_data_valid", 32'(data_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_outstanding", 32'(outstanding), 32'd0);
        chk("midrst_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(LAT + 4);

        // recovery after reset
        do_read(16'h0040);
        do_read(16'h123E);
        idle(LAT + 2);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
